instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
// - Instruction-supply side of the sequencer: owns program memory, answers PC-driven fetches from control.
// - Host streams a program in bytewise (valid/ready), then releases the core; each cycle returns the
//   instruction at the address control will present as program_counter next cycle.
// - Holds control in reset (core_rst) while loading; sits between host loader and control.
// PARAMETERS
// - ADDR_W     12     byte address width; matches control PC width
// - INSTR_W    16     instruction width (2 bytes)
// - MEM_WORDS  2048   program memory depth in words = 2**(ADDR_W-1)
// PORTS
// - clk          in   1        clock
// - rst          in   1        reset, synchronous, active-high
// - load_start   in   1        pulse: begin new program load (IDLE or RUN)
// - run_start    in   1        pulse: run resident program from addr 0 (IDLE only)
// - ld_valid     in   1        load byte valid
// - ld_data      in   8        load byte
// - ld_last      in   1        qualifies final byte of program (with ld_valid)
// - ld_ready     out  1        loader accepts byte this cycle
// - next_pc      in   ADDR_W   control next_program_counter (fetch address)
// - instruction  out  INSTR_W  registered instruction for control current PC
// - core_rst     out  1        reset to control/datapath
// - running      out  1        1 in RUN
// - load_err     out  1        sticky: load exceeded 2**ADDR_W bytes; cleared by next load_start/rst
// BEHAVIOUR
// - Reset: state IDLE, core_rst=1, running=0, ld_ready=0, instruction=0, load_err=0, byte counter=0,
//   pending-byte latch cleared; memory contents NOT cleared.
// - States: IDLE -> LOAD on load_start; IDLE -> ARM on run_start (load_start wins if both);
//   LOAD -> ARM when ld_valid&ld_ready&ld_last; ARM -> RUN after exactly 1 cycle;
//   RUN -> LOAD on load_start (run_start ignored in RUN/LOAD/ARM).
// - core_rst=1 in IDLE, LOAD, ARM; 0 only in RUN. running=1 only in RUN.
// - LOAD: ld_ready=1 every cycle. Byte order big-endian: even byte -> instr[15:8] (latched),
//   odd byte -> instr[7:0]; word written to mem[byte_addr[ADDR_W-1:1]] on odd-byte acceptance.
// - ld_last on even byte: word written with low byte 8'h00 same cycle.
// - byte_addr starts at 0 on entry to LOAD, +1 per accepted byte. Byte accepted at addr 2**ADDR_W
//   or beyond: dropped (no write, no wrap), load_err set; ld_ready stays 1 until ld_last.
// - Fetch: synchronous read. fetch_addr = (state==ARM) ? 0 : next_pc; word index = fetch_addr[ADDR_W-1:1],
//   bit 0 ignored. instruction <= mem[index] when state in {ARM,RUN}, else <= 0.
//   Net: first RUN cycle instruction=mem[0] while control PC=0; thereafter 1-cycle read latency
//   matched to control's registered PC. Jumps/calls/returns need no bubble.
// - No read/write collision: writes only in LOAD, reads only in ARM/RUN.
// - load_start in RUN: next cycle LOAD, core_rst=1, instruction=0; control state discarded.
// - rst mid-LOAD: IDLE; partially written words remain; load_err cleared.
// STRUCTURE
// - Shared package (fetch_pkg or isa header): state enum {IDLE,LOAD,ARM,RUN}, ADDR_W/INSTR_W constants.
// - Sub-module prog_mem: simple dual-port sync RAM, 1 write port (LOAD), 1 registered read port.
// - Top: FSM, byte counter, even-byte latch, fetch address mux, load_err flag.
// TESTING
// - Reset: after rst, core_rst=1, running=0, ld_ready=0, instruction=0, load_err=0.
// - Load 4 bytes 12,34,56,78 (last on 78) -> mem[0]=16'h1234, mem[1]=16'h5678; ARM 1 cycle;
//   first RUN cycle instruction=16'h1234; next_pc=2 -> next cycle 16'h5678.
// - Odd load 3 bytes AB,CD,EF -> mem[1]=16'hEF00; next_pc=12'h002 in RUN -> 16'hEF00.
// - Random next_pc sequence 0x0,0x6,0x7,0x2 in RUN -> instruction tracks mem[0],mem[3],mem[3],mem[1]
//   with 1-cycle lag; bit 0 ignored.
// - Overflow: 4098 bytes -> load_err=1, mem[0] unchanged by bytes 4096/4097, ARM reached on ld_last.
// - load_start mid-RUN and rst mid-LOAD -> core_rst=1 next cycle; run_start in IDLE replays mem[0].

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch block: sequencer states and
// default geometry of the program memory.
package fetch_pkg;

    localparam int IF_ADDR_W    = 12;
    localparam int IF_INSTR_W   = 16;
    localparam int IF_MEM_WORDS = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ARM  = 2'd2,
        RUN  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program memory: one synchronous write port for the loader and one
// registered read port that returns zero whenever the read is not enabled.
module instr_fetch_prog_mem #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rd_data_r;

    // Write port: contents survive rst so a resident program can be replayed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {DW{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= {DW{1'b0}};
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction supply for the sequencer: loads a program bytewise from the host,
// holds the core in reset meanwhile, then serves PC-driven fetches.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = IF_ADDR_W,
    parameter int INSTR_W   = IF_INSTR_W,
    parameter int MEM_WORDS = IF_MEM_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               run_start,
    input  logic               ld_valid,
    input  logic [7:0]         ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    input  logic [ADDR_W-1:0]  next_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               core_rst,
    output logic               running,
    output logic               load_err
);

    localparam int WORD_AW = ADDR_W - 1;

    fetch_state_e        state_r;
    fetch_state_e        state_s;
    logic [ADDR_W:0]     byte_addr_r;
    logic [7:0]          hi_byte_r;
    logic                ld_ready_r;
    logic                core_rst_r;
    logic                running_r;
    logic                load_err_r;

    logic                accept_s;
    logic                overflow_s;
    logic                enter_load_s;
    logic                wr_en_s;
    logic [WORD_AW-1:0]  wr_addr_s;
    logic [INSTR_W-1:0]  wr_data_s;
    logic [ADDR_W-1:0]   fetch_addr_s;
    logic [WORD_AW-1:0]  rd_addr_s;
    logic                rd_en_s;
    logic                unused_fetch_bit_s;

    // Next-state logic; load_start takes priority over run_start in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    state_s = LOAD;
                end else if (run_start) begin
                    state_s = ARM;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (accept_s && ld_last) begin
                    state_s = ARM;
                end else begin
                    state_s = LOAD;
                end
            end
            ARM: begin
                state_s = RUN;
            end
            RUN: begin
                if (load_start) begin
                    state_s = LOAD;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Loader write path and fetch address selection.
    always_comb begin
        accept_s     = ld_valid & ld_ready_r;
        overflow_s   = byte_addr_r[ADDR_W];
        enter_load_s = (state_s == LOAD) && (state_r != LOAD);
        // A final even byte closes its word with a zero low byte.
        wr_en_s      = accept_s & ~overflow_s & (byte_addr_r[0] | ld_last);
        wr_addr_s    = byte_addr_r[ADDR_W-1:1];
        wr_data_s    = byte_addr_r[0] ? {hi_byte_r, ld_data} : {ld_data, 8'h00};
        // ARM primes address 0 so the first RUN cycle matches control's PC of 0.
        fetch_addr_s = (state_r == ARM) ? {ADDR_W{1'b0}} : next_pc;
        rd_addr_s    = fetch_addr_s[ADDR_W-1:1];
        unused_fetch_bit_s = fetch_addr_s[0];
        rd_en_s      = ((state_r == ARM) || (state_r == RUN)) &&
                       ((state_s == ARM) || (state_s == RUN));
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ld_ready_r <= 1'b0;
            core_rst_r <= 1'b1;
            running_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            ld_ready_r <= (state_s == LOAD);
            core_rst_r <= (state_s != RUN);
            running_r  <= (state_s == RUN);
        end
    end

    // Byte counter, even-byte latch and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_addr_r <= {(ADDR_W+1){1'b0}};
            hi_byte_r   <= 8'h00;
            load_err_r  <= 1'b0;
        end else if (enter_load_s) begin
            byte_addr_r <= {(ADDR_W+1){1'b0}};
            hi_byte_r   <= 8'h00;
            load_err_r  <= 1'b0;
        end else if (accept_s && overflow_s) begin
            byte_addr_r <= byte_addr_r;
            hi_byte_r   <= hi_byte_r;
            load_err_r  <= 1'b1;
        end else if (accept_s) begin
            byte_addr_r <= byte_addr_r + {{ADDR_W{1'b0}}, 1'b1};
            hi_byte_r   <= byte_addr_r[0] ? hi_byte_r : ld_data;
            load_err_r  <= load_err_r;
        end else begin
            byte_addr_r <= byte_addr_r;
            hi_byte_r   <= hi_byte_r;
            load_err_r  <= load_err_r;
        end
    end

    instr_fetch_prog_mem #(
        .DEPTH (MEM_WORDS),
        .AW    (WORD_AW),
        .DW    (INSTR_W)
    ) u_prog_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (instruction)
    );

    assign ld_ready = ld_ready_r;
    assign core_rst = core_rst_r;
    assign running  = running_r;
    assign load_err = load_err_r;

endmodule
